game_timer: RTL and testbench

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_timer_if.sv | 49 ++++
 rtl/game_timer.sv | 202 ++++++++++++++++++++
 tb/tb_game_timer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_timer_if.sv
// ----------------------------------------------------------------------------
// game_timer_if
//
// Purpose:
//   Bundles the game-timer control inputs and status outputs into one
//   interface. The clock and reset stay outside as plain ports.
//
// Signals:
//   start      : level, enter RUN from IDLE or PAUSED
//   pause      : level, enter PAUSED from RUN
//   restart    : level, reload the start value and return to IDLE
//   timerdig2  : BCD minutes digit (X:00)
//   timerdig1  : BCD seconds-tens digit (0:X0), 0..5
//   timerdig0  : BCD seconds-ones digit (0:0X), 0..9
//   running    : high while counting down
//   expired    : high once the countdown has reached 0:00
//   done       : one-cycle pulse on entry to EXPIRED
//   tick       : one-cycle pulse on every one-second decrement
//   warn       : low-time indicator (under 0:30 while RUN/PAUSED)
//
// Modports:
//   master : the controller side (drives controls, reads status)
//   slave  : the timer side (reads controls, drives status)
// ----------------------------------------------------------------------------
interface game_timer_if;
    logic       start;
    logic       pause;
    logic       restart;
    logic [3:0] timerdig2;
    logic [3:0] timerdig1;
    logic [3:0] timerdig0;
    logic       running;
    logic       expired;
    logic       done;
    logic       tick;
    logic       warn;

    modport master (
        output start, pause, restart,
        input  timerdig2, timerdig1, timerdig0,
        input  running, expired, done, tick, warn
    );

    modport slave (
        input  start, pause, restart,
        output timerdig2, timerdig1, timerdig0,
        output running, expired, done, tick, warn
    );
endinterface

// File: rtl/game_timer.sv
// ----------------------------------------------------------------------------
// game_timer
//
// Purpose:
//   Minutes:seconds countdown timer for the game menu. A prescaler divides
//   clk down to one-second ticks; each tick decrements a three-digit BCD
//   value (M:ST). States: IDLE, RUN, PAUSED, EXPIRED. All outputs are
//   registered.
//
// Parameters:
//   CLK_HZ    : clock cycles per one-second tick (2 .. 2^26)
//   START_MIN : minutes digit loaded on reset/restart (0..9)
//   START_SEC : seconds loaded on reset/restart (0..59), split into BCD
//               tens/ones at elaboration
//
// Ports:
//   clk      : sole clock, rising edge
//   reset_n  : synchronous, active-low reset
//   tif      : game_timer_if.slave (start/pause/restart in; digits,
//              running, expired, done, tick, warn out)
//
// Configuration:
//   GAME_TIMER_WARN_EN : when defined, warn is high in RUN or PAUSED while the
//                        remaining time is below 0:30. When undefined, warn is
//                        tied low and no comparison logic exists.
// ----------------------------------------------------------------------------
module game_timer #(
    parameter int CLK_HZ    = 25000000,
    parameter int START_MIN = 3,
    parameter int START_SEC = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    game_timer_if.slave tif
);

    localparam int            PW         = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
    localparam logic [3:0]    START_MINS = 4'(START_MIN);
    localparam logic [3:0]    START_TENS = 4'(START_SEC / 10);
    localparam logic [3:0]    START_ONES = 4'(START_SEC % 10);
    localparam bit            START_ZERO = (START_MIN == 0) && (START_SEC == 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] prescale;
    logic [3:0]    dig2;
    logic [3:0]    dig1;
    logic [3:0]    dig0;
    logic          running;
    logic          expired;
    logic          done;
    logic          tick;

    logic [11:0]   dec;
    logic          last_sec;
    logic          wrap;

    // One-second BCD decrement with borrow ones -> tens -> minutes.
    // 0:00 is held rather than wrapping, so the value can never underflow.
    function automatic logic [11:0] bcd_dec(input logic [3:0] m,
                                            input logic [3:0] t,
                                            input logic [3:0] o);
        logic [3:0] m_n;
        logic [3:0] t_n;
        logic [3:0] o_n;
        m_n = m;
        t_n = t;
        o_n = o;
        if (o != 4'd0) begin
            o_n = o - 4'd1;
        end else if (t != 4'd0) begin
            o_n = 4'd9;
            t_n = t - 4'd1;
        end else if (m != 4'd0) begin
            o_n = 4'd9;
            t_n = 4'd5;
            m_n = m - 4'd1;
        end
        return {m_n, t_n, o_n};
    endfunction

    assign dec      = bcd_dec(dig2, dig1, dig0);
    assign last_sec = (dig2 == 4'd0) && (dig1 == 4'd0) && (dig0 == 4'd1);
    assign wrap     = (prescale == PRE_LAST);

    // Control FSM, prescaler and digit registers. restart shares the reset
    // path so it reloads everything and lands in IDLE on the next edge, which
    // also gives it priority over pause and start.
    always_ff @(posedge clk) begin
        if (!reset_n || tif.restart) begin
            state    <= IDLE;
            prescale <= '0;
            dig2     <= START_MINS;
            dig1     <= START_TENS;
            dig0     <= START_ONES;
            running  <= 1'b0;
            expired  <= 1'b0;
            done     <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tif.start) begin
                        // A 0:00 start value has nothing to count down.
                        if (START_ZERO) begin
                            state   <= EXPIRED;
                            expired <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (tif.pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else if (wrap) begin
                        prescale           <= '0;
                        tick               <= 1'b1;
                        {dig2, dig1, dig0} <= dec;
                        // The tick that reaches 0:00 also expires the timer.
                        if (last_sec) begin
                            state   <= EXPIRED;
                            running <= 1'b0;
                            expired <= 1'b1;
                            done    <= 1'b1;
                        end
                    end else begin
                        prescale <= prescale + PW'(1);
                    end
                end
                PAUSED: begin
                    // Prescaler is left untouched so partial-second
                    // progress carries over into the resumed run.
                    if (tif.start && !tif.pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    // EXPIRED: only restart or reset leave this state.
                end
            endcase
        end
    end

`ifdef GAME_TIMER_WARN_EN
    logic warn;

    function automatic logic low_time(input logic [3:0] m, input logic [3:0] t);
        return (m == 4'd0) && (t < 4'd3);
    endfunction

    // warn tracks the digits loaded alongside the FSM transitions above.
    // It only changes when the digits change or RUN/PAUSED is entered/left;
    // pause and resume keep the digits, so warn simply holds across them.
    always_ff @(posedge clk) begin
        if (!reset_n || tif.restart) begin
            warn <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tif.start && !START_ZERO) begin
                        warn <= low_time(START_MINS, START_TENS);
                    end
                end
                RUN: begin
                    if (!tif.pause && wrap) begin
                        warn <= !last_sec && low_time(dec[11:8], dec[7:4]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tif.warn = warn;
`else
    assign tif.warn = 1'b0;
`endif

    assign tif.timerdig2 = dig2;
    assign tif.timerdig1 = dig1;
    assign tif.timerdig0 = dig0;
    assign tif.running   = running;
    assign tif.expired   = expired;
    assign tif.done      = done;
    assign tif.tick      = tick;

endmodule

// File: tb/tb_game_timer.sv
// ----------------------------------------------------------------------------
// tb_game_timer
//
// Directed bench for game_timer with CLK_HZ=4 and the default 3:00 start.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each step() shows the result of exactly one clock edge.
// ----------------------------------------------------------------------------
module tb_game_timer;
    logic clk = 1'b0;
    logic reset_n;

    game_timer_if tif();

    game_timer #(
        .CLK_HZ   (4),
        .START_MIN(3),
        .START_SEC(0)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .tif    (tif)
    );

    always #5 clk = ~clk;

`ifdef GAME_TIMER_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [11:0] digits;

    assign digits = {tif.timerdig2, tif.timerdig1, tif.timerdig0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick is seen; cycles is the number of edges taken, or 99
    // if no tick appeared within the budget.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (tif.tick !== 1'b1 && cycles < 8);
        if (tif.tick !== 1'b1) cycles = 99;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        tif.start   = 1'b0;
        tif.pause   = 1'b0;
        tif.restart = 1'b0;
        step();
        step();
        checks++; if (digits !== 12'h300) begin failures++; $display("FAIL reset_digits got=%h exp=300", digits); end
        checks++; if (tif.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", tif.running); end
        checks++; if (tif.expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0", tif.expired); end
        checks++; if (tif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", tif.done); end
        checks++; if (tif.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tif.tick); end
        checks++; if (tif.warn !== 1'b0) begin failures++; $display("FAIL reset_warn got=%b exp=0", tif.warn); end
        reset_n = 1'b1;
        step();
        step();
        checks++; if (tif.running !== 1'b0 || digits !== 12'h300) begin
            failures++; $display("FAIL idle_hold running=%b digits=%h exp running=0 digits=300", tif.running, digits);
        end
    endtask

    // Start for one cycle; first tick lands 4 edges later with 2:59.
    task automatic test_first_tick();
        tif.start = 1'b1;
        step();
        tif.start = 1'b0;
        checks++; if (tif.running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", tif.running); end
        step();
        step();
        step();
        checks++; if (tif.tick !== 1'b0 || digits !== 12'h300) begin
            failures++; $display("FAIL pre_tick tick=%b digits=%h exp tick=0 digits=300", tif.tick, digits);
        end
        step();
        checks++; if (tif.tick !== 1'b1) begin failures++; $display("FAIL first_tick got=%b exp=1", tif.tick); end
        checks++; if (digits !== 12'h259) begin failures++; $display("FAIL first_digits got=%h exp=259", digits); end
    endtask

    // Ticks 2..60: steady 4-cycle period, 2:48 at tick 12, 2:00 at tick 60.
    task automatic test_borrow();
        int c;
        for (int n = 2; n <= 60; n++) begin
            wait_tick(c);
            checks++; if (c !== 4) begin failures++; $display("FAIL tick_period n=%0d got=%0d exp=4", n, c); end
            if (n == 12) begin
                checks++; if (digits !== 12'h248) begin failures++; $display("FAIL digits_t12 got=%h exp=248", digits); end
            end
        end
        checks++; if (digits !== 12'h200) begin failures++; $display("FAIL digits_t60 got=%h exp=200", digits); end
        checks++; if (tif.running !== 1'b1 || tif.done !== 1'b0) begin
            failures++; $display("FAIL t60_state running=%b done=%b exp running=1 done=0", tif.running, tif.done);
        end
    endtask

    // Pause lands with prescaler at 2; resume must tick 2 edges later.
    task automatic test_pause_resume();
        bit saw_tick;
        step();
        step();
        tif.pause = 1'b1;
        step();
        checks++; if (tif.running !== 1'b0) begin failures++; $display("FAIL pause_running got=%b exp=0", tif.running); end
        saw_tick = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (tif.tick === 1'b1) saw_tick = 1'b1;
        end
        checks++; if (saw_tick !== 1'b0) begin failures++; $display("FAIL paused_tick got=%b exp=0", saw_tick); end
        checks++; if (digits !== 12'h200) begin failures++; $display("FAIL paused_digits got=%h exp=200", digits); end
        tif.pause = 1'b0;
        tif.start = 1'b1;
        step();
        tif.start = 1'b0;
        checks++; if (tif.running !== 1'b1 || tif.tick !== 1'b0) begin
            failures++; $display("FAIL resume running=%b tick=%b exp running=1 tick=0", tif.running, tif.tick);
        end
        step();
        checks++; if (tif.tick !== 1'b0) begin failures++; $display("FAIL resume_early_tick got=%b exp=0", tif.tick); end
        step();
        checks++; if (tif.tick !== 1'b1) begin failures++; $display("FAIL resume_tick got=%b exp=1", tif.tick); end
        checks++; if (digits !== 12'h159) begin failures++; $display("FAIL resume_digits got=%h exp=159", digits); end
    endtask

    // Ticks 62..113 reach 1:07; restart+pause mid-second -> IDLE at 3:00.
    task automatic test_restart_priority();
        int c;
        for (int n = 62; n <= 113; n++) begin
            wait_tick(c);
            checks++; if (c !== 4) begin failures++; $display("FAIL tick_period n=%0d got=%0d exp=4", n, c); end
        end
        checks++; if (digits !== 12'h107) begin failures++; $display("FAIL digits_107 got=%h exp=107", digits); end
        step();
        step();
        tif.restart = 1'b1;
        tif.pause   = 1'b1;
        step();
        tif.restart = 1'b0;
        tif.pause   = 1'b0;
        checks++; if (tif.running !== 1'b0) begin failures++; $display("FAIL restart_running got=%b exp=0", tif.running); end
        checks++; if (digits !== 12'h300) begin failures++; $display("FAIL restart_digits got=%h exp=300", digits); end
        checks++; if (tif.tick !== 1'b0 || tif.expired !== 1'b0) begin
            failures++; $display("FAIL restart_flags tick=%b expired=%b exp 0 0", tif.tick, tif.expired);
        end
        for (int i = 0; i < 5; i++) step();
        checks++; if (tif.running !== 1'b0 || digits !== 12'h300) begin
            failures++; $display("FAIL restart_idle running=%b digits=%h exp running=0 digits=300", tif.running, digits);
        end
        // A cleared prescaler gives a full 4-cycle first second.
        tif.start = 1'b1;
        step();
        tif.start = 1'b0;
        wait_tick(c);
        checks++; if (c !== 4) begin failures++; $display("FAIL restart_prescale got=%0d exp=4", c); end
        checks++; if (digits !== 12'h259) begin failures++; $display("FAIL restart_first got=%h exp=259", digits); end
    endtask

    // Ticks 2..180 from the fresh run: warn window, expiry and done pulse.
    task automatic test_expire_warn();
        int c;
        logic exp_warn;
        for (int n = 2; n <= 180; n++) begin
            wait_tick(c);
            checks++; if (c !== 4) begin failures++; $display("FAIL tick_period n=%0d got=%0d exp=4", n, c); end
            exp_warn = WARN_ON && (n >= 151) && (n < 180);
            checks++; if (tif.warn !== exp_warn) begin failures++; $display("FAIL warn n=%0d got=%b exp=%b", n, tif.warn, exp_warn); end
            if (n == 150) begin
                checks++; if (digits !== 12'h030) begin failures++; $display("FAIL digits_030 got=%h exp=030", digits); end
            end
            if (n == 151) begin
                checks++; if (digits !== 12'h029) begin failures++; $display("FAIL digits_029 got=%h exp=029", digits); end
            end
        end
        checks++; if (digits !== 12'h000) begin failures++; $display("FAIL expire_digits got=%h exp=000", digits); end
        checks++; if (tif.expired !== 1'b1) begin failures++; $display("FAIL expire_flag got=%b exp=1", tif.expired); end
        checks++; if (tif.done !== 1'b1) begin failures++; $display("FAIL expire_done got=%b exp=1", tif.done); end
        checks++; if (tif.running !== 1'b0) begin failures++; $display("FAIL expire_running got=%b exp=0", tif.running); end
        step();
        checks++; if (tif.done !== 1'b0 || tif.tick !== 1'b0) begin
            failures++; $display("FAIL done_pulse done=%b tick=%b exp 0 0", tif.done, tif.tick);
        end
        checks++; if (tif.expired !== 1'b1) begin failures++; $display("FAIL expired_hold got=%b exp=1", tif.expired); end
        tif.start = 1'b1;
        step();
        tif.start = 1'b0;
        tif.pause = 1'b1;
        step();
        tif.pause = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (digits !== 12'h000 || tif.expired !== 1'b1 || tif.running !== 1'b0) begin
            failures++; $display("FAIL expired_ignore digits=%h expired=%b running=%b exp 000 1 0", digits, tif.expired, tif.running);
        end
        checks++; if (tif.done !== 1'b0 || tif.tick !== 1'b0) begin
            failures++; $display("FAIL expired_quiet done=%b tick=%b exp 0 0", tif.done, tif.tick);
        end
    endtask

    // Restart from EXPIRED, reset mid-second overriding start, pause
    // ignored in IDLE, then two consecutive ticks.
    task automatic test_back_to_back();
        int c;
        tif.restart = 1'b1;
        step();
        tif.restart = 1'b0;
        checks++; if (tif.expired !== 1'b0 || digits !== 12'h300) begin
            failures++; $display("FAIL restart_expired expired=%b digits=%h exp 0 300", tif.expired, digits);
        end
        tif.start = 1'b1;
        step();
        tif.start = 1'b0;
        step();
        step();
        reset_n   = 1'b0;
        tif.start = 1'b1;
        step();
        reset_n   = 1'b1;
        tif.start = 1'b0;
        checks++; if (tif.running !== 1'b0 || digits !== 12'h300 || tif.tick !== 1'b0) begin
            failures++; $display("FAIL reset_midrun running=%b digits=%h tick=%b exp 0 300 0", tif.running, digits, tif.tick);
        end
        tif.pause = 1'b1;
        step();
        tif.pause = 1'b0;
        checks++; if (tif.running !== 1'b0) begin failures++; $display("FAIL idle_pause got=%b exp=0", tif.running); end
        tif.start = 1'b1;
        step();
        tif.start = 1'b0;
        wait_tick(c);
        checks++; if (c !== 4 || digits !== 12'h259) begin
            failures++; $display("FAIL b2b_first cycles=%0d digits=%h exp 4 259", c, digits);
        end
        wait_tick(c);
        checks++; if (c !== 4 || digits !== 12'h258) begin
            failures++; $display("FAIL b2b_second cycles=%0d digits=%h exp 4 258", c, digits);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_tick();
        test_borrow();
        test_pause_resume();
        test_restart_priority();
        test_expire_warn();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
